// File: rtl/mips_isa_pkg.sv
// Mini-MIPS ISA constants shared by the encoder/loader
// and the opcode/funct control decoder.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_R     = 4'd0,
    OP_LW    = 4'd1,
    OP_SW    = 4'd2,
    OP_BEQ   = 4'd3,
    OP_BNE   = 4'd4,
    OP_ADDI  = 4'd5,
    OP_ANDI  = 4'd6,
    OP_ORI   = 4'd7,
    OP_XORI  = 4'd8,
    OP_LUI   = 4'd9,
    OP_SLTI  = 4'd10,
    OP_SLTIU = 4'd11,
    OP_J     = 4'd12
  } op_e;

  localparam logic [5:0] OPC_R     = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_J     = 6'b000010;

  function automatic logic [31:0] itype(
    input logic [5:0]  opc,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_loader_if.sv
// Instruction-beat valid/ready channel into the
// encoder/loader.
interface mips_instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt,
    output in_rd, in_shamt, in_funct,
    output in_imm, in_target, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt,
    input  in_rd, in_shamt, in_funct,
    input  in_imm, in_target, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_word_pack.sv
// Combinational class-to-word packer; legal=0 for
// op codes outside the enum.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (op)
      OP_R:
        word = {OPC_R, rs, rt, rd, shamt, funct};
      OP_LW:    word = itype(OPC_LW, rs, rt, imm);
      OP_SW:    word = itype(OPC_SW, rs, rt, imm);
      OP_BEQ:   word = itype(OPC_BEQ, rs, rt, imm);
      OP_BNE:   word = itype(OPC_BNE, rs, rt, imm);
      OP_ADDI:  word = itype(OPC_ADDI, rs, rt, imm);
      OP_ANDI:  word = itype(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = itype(OPC_ORI, rs, rt, imm);
      OP_XORI:  word = itype(OPC_XORI, rs, rt, imm);
      // LUI has no source register
      OP_LUI:   word = itype(OPC_LUI, 5'd0, rt, imm);
      OP_SLTI:  word = itype(OPC_SLTI, rs, rt, imm);
      OP_SLTIU: word = itype(OPC_SLTIU, rs, rt, imm);
      OP_J:     word = {OPC_J, target};
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// Streams encoded MIPS words into instruction memory
// from a programmed base address.
module mips_instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  mips_instr_encoder_loader_if.slave ins,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_full,
  output logic              err_op
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(IMEM_DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              legal;
  logic              hs;

  mips_word_pack u_pack (
    .op     (ins.in_op),
    .rs     (ins.in_rs),
    .rt     (ins.in_rt),
    .rd     (ins.in_rd),
    .shamt  (ins.in_shamt),
    .funct  (ins.in_funct),
    .imm    (ins.in_imm),
    .target (ins.in_target),
    .word   (word),
    .legal  (legal)
  );

  assign hs = ins.in_valid && ins.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      ins.in_ready <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
      err_full     <= 1'b0;
      err_op       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            ptr          <= base_addr;
            word_count   <= '0;
            err_full     <= 1'b0;
            err_op       <= 1'b0;
            ins.in_ready <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= word;
              word_count <= word_count + 1'b1;
              if (ptr != LAST)
                ptr <= ptr + 1'b1;
            end else begin
              err_op <= 1'b1;
            end
            if (ins.in_last) begin
              ins.in_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= ST_DONE;
            end else if (legal && ptr == LAST) begin
              ins.in_ready <= 1'b0;
            end
          end else if (!ins.in_ready &&
                       ins.in_valid) begin
            // stalled only when memory is full
            err_full <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed bench with a write scoreboard for the
// MIPS instruction encoder/loader.
module tb_mips_instr_encoder_loader;
  import mips_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [8:0]  word_count;
  logic        err_full;
  logic        err_op;

  mips_instr_encoder_loader_if ins ();

  mips_instr_encoder_loader #(
    .IMEM_DEPTH (256),
    .ADDR_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .ins        (ins.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err_full   (err_full),
    .err_op     (err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  task automatic push_exp(
    input logic [7:0]  a,
    input logic [31:0] d
  );
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got %0h@%0h want none",
                 imem_wdata, imem_addr);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", {56'd0, imem_addr}, {56'd0, e.a});
        chk("wr_data", {32'd0, imem_wdata}, {32'd0, e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    cyc();
    start = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_rdy", {63'd0, ins.in_ready}, 64'd1);
  endtask

  task automatic send(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  fn,
    input logic [15:0] imm,
    input logic [25:0] tgt,
    input logic        last
  );
    int k;
    ins.in_op     = op;
    ins.in_rs     = rs;
    ins.in_rt     = rt;
    ins.in_rd     = rd;
    ins.in_shamt  = 5'd0;
    ins.in_funct  = fn;
    ins.in_imm    = imm;
    ins.in_target = tgt;
    ins.in_last   = last;
    ins.in_valid  = 1'b1;
    k = 0;
    while (!ins.in_ready && k < 20) begin
      cyc();
      k++;
    end
    if (!ins.in_ready) begin
      total++;
      $display("FAIL send_timeout: got ready=0 want 1");
      ins.in_valid = 1'b0;
    end else begin
      cyc();
      ins.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string n);
    int k;
    k = 0;
    while (!done && k < 8) begin
      cyc();
      k++;
    end
    chk(n, {63'd0, done}, 64'd1);
    chk({n, "_busy"}, {63'd0, busy}, 64'd0);
    ins.in_valid = 1'b0;
    cyc();
    chk({n, "_once"}, {63'd0, done}, 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return {34'd0, ins.in_ready, imem_we,
            busy, done, err_full, err_op,
            word_count, imem_addr, 8'd0} |
           {32'd0, imem_wdata};
  endfunction

  initial begin
    ins.in_valid  = 1'b0;
    ins.in_op     = '0;
    ins.in_rs     = '0;
    ins.in_rt     = '0;
    ins.in_rd     = '0;
    ins.in_shamt  = '0;
    ins.in_funct  = '0;
    ins.in_imm    = '0;
    ins.in_target = '0;
    ins.in_last   = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    chk("reset_outs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 1: ADDI then R with last
    go(8'h10);
    push_exp(8'h10, 32'h2008_0005);
    push_exp(8'h11, 32'h0109_5020);
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 6'd0,
         16'd5, 26'd0, 1'b0);
    send(OP_R, 5'd8, 5'd9, 5'd10, 6'h20,
         16'd0, 26'd0, 1'b1);
    wait_done("t1_done");
    chk("t1_wc", {55'd0, word_count}, 64'd2);

    // 2: LW, LUI (rs ignored), J
    go(8'h20);
    push_exp(8'h20, 32'h8FA8_0004);
    push_exp(8'h21, 32'h3C01_1234);
    push_exp(8'h22, 32'h0800_0010);
    send(OP_LW, 5'd29, 5'd8, 5'd0, 6'd0,
         16'h0004, 26'd0, 1'b0);
    send(OP_LUI, 5'd3, 5'd1, 5'd0, 6'd0,
         16'h1234, 26'd0, 1'b0);
    send(OP_J, 5'd0, 5'd0, 5'd0, 6'd0,
         16'd0, 26'h10, 1'b1);
    wait_done("t2_done");
    chk("t2_wc", {55'd0, word_count}, 64'd3);

    // 3: valid 1,0,1
    go(8'h40);
    push_exp(8'h40, 32'h3422_00FF);
    push_exp(8'h41, 32'h3064_0F0F);
    send(OP_ORI, 5'd1, 5'd2, 5'd0, 6'd0,
         16'h00FF, 26'd0, 1'b0);
    chk("t3_we1", {63'd0, imem_we}, 64'd1);
    cyc();
    chk("t3_gap", {63'd0, imem_we}, 64'd0);
    send(OP_ANDI, 5'd3, 5'd4, 5'd0, 6'd0,
         16'h0F0F, 26'd0, 1'b1);
    chk("t3_we2", {63'd0, imem_we}, 64'd1);
    wait_done("t3_done");

    // 4: run off the end of memory
    go(8'hFE);
    push_exp(8'hFE, 32'hAC43_0008);
    push_exp(8'hFF, 32'h1085_FFFF);
    send(OP_SW, 5'd2, 5'd3, 5'd0, 6'd0,
         16'h0008, 26'd0, 1'b0);
    send(OP_BEQ, 5'd4, 5'd5, 5'd0, 6'd0,
         16'hFFFF, 26'd0, 1'b0);
    chk("t4_rdy", {63'd0, ins.in_ready}, 64'd0);
    ins.in_op    = OP_XORI;
    ins.in_valid = 1'b1;
    wait_done("t4_done");
    chk("t4_full", {63'd0, err_full}, 64'd1);
    chk("t4_wc", {55'd0, word_count}, 64'd2);
    chk("t4_op", {63'd0, err_op}, 64'd0);

    // 5: illegal op between legal beats
    go(8'h80);
    chk("t5_clr", {63'd0, err_full}, 64'd0);
    push_exp(8'h80, 32'h2822_0003);
    push_exp(8'h81, 32'h14C7_0010);
    send(OP_SLTI, 5'd1, 5'd2, 5'd0, 6'd0,
         16'h0003, 26'd0, 1'b0);
    send(4'd14, 5'd1, 5'd1, 5'd1, 6'd1,
         16'h1111, 26'd0, 1'b0);
    send(OP_BNE, 5'd6, 5'd7, 5'd0, 6'd0,
         16'h0010, 26'd0, 1'b1);
    wait_done("t5_done");
    chk("t5_err", {63'd0, err_op}, 64'd1);
    chk("t5_wc", {55'd0, word_count}, 64'd2);

    // 6: reset mid-stream
    go(8'h30);
    push_exp(8'h30, 32'h2008_0001);
    push_exp(8'h31, 32'h2008_0002);
    push_exp(8'h32, 32'h2008_0003);
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 6'd0,
         16'd1, 26'd0, 1'b0);
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 6'd0,
         16'd2, 26'd0, 1'b0);
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 6'd0,
         16'd3, 26'd0, 1'b0);
    ins.in_imm   = 16'd4;
    ins.in_valid = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6_rdy", {63'd0, ins.in_ready}, 64'd0);
    end
    ins.in_valid = 1'b0;
    cyc();
    chk("t6_idle", {62'd0, busy, imem_we}, 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_instr_encoder_loader.md
Name: mips_instr_encoder_loader

Overview:
Streaming instruction encoder and loader for the mini-MIPS core: the encode-side counterpart of the opcode/funct control decoder. It accepts decoded instruction fields (class, registers, immediate, target) over a valid/ready handshake. It packs each beat into a 32-bit MIPS R/I/J word and writes the words to consecutive instruction-memory addresses from a programmed base. It is used by the test harness and boot path to load programs (e.g. bucket sort) before the core is released.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in words.
ADDR_W, 8, width of the word address; clog2(IMEM_DEPTH).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load session at base_addr; sampled only in IDLE
base_addr  in  ADDR_W  first word address of the session
in_valid  in  1  instruction beat valid
in_ready  out  1  encoder can accept a beat
in_op  in  4  instruction class code (package enum)
in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
in_funct  in  6  R-type function code
in_imm  in  16  I-type immediate
in_target  in  26  J-type target
in_last  in  1  final beat of the session
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded word
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end
word_count  out  ADDR_W+1  words written in the current/last session
err_full  out  1  sticky: session ran past IMEM_DEPTH-1
err_op  out  1  sticky: illegal in_op received

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: in_ready, imem_we, imem_addr, imem_wdata, busy, done, word_count, err_full, err_op.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0. start=1 loads ptr<=base_addr, clears word_count, err_full and err_op, and moves to RUN.
- RUN: busy=1. in_ready=1 unless a write to address IMEM_DEPTH-1 has already been issued this session. start is ignored.
- A handshake occurs when in_valid&&in_ready.
- Accepted legal beat at cycle t:
  - At t+1, imem_we=1, imem_addr=ptr and imem_wdata=the encoded word. These outputs are registered, so latency is 1 cycle.
  - Throughput is 1 word per cycle.
  - ptr increments and word_count increments.
- Encoding:
  - R (OP_R): {6'b000000, rs, rt, rd, shamt, funct}.
  - I (LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011): {opc, rs, rt, imm}.
  - LUI (001111): rs field forced to 0.
  - J (000010): {opc, target}.
- Illegal in_op (codes 13-15): the beat is consumed and err_op is set. No write is issued and ptr does not advance. If in_last is set, the session still ends.
- in_last accepted: the write, if any, issues at t+1. State goes to DONE at t+1.
- Full:
  - A legal beat written to address IMEM_DEPTH-1 without in_last drops in_ready at t+1.
  - If in_valid is then seen high in RUN, err_full is set and state goes to DONE. That beat is not consumed.
  - Writing the last address with in_last set is a normal completion with no error.
  - ptr never wraps.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0. Next state is IDLE.
- imem_we deasserts the cycle after any cycle with no accepted legal beat.
- rst_n asserted mid-session aborts the session immediately. No further writes occur, and the state after release is IDLE.

Decomposition:
- Package mips_isa_pkg: the in_op enum (OP_R=0, LW=1, SW=2, BEQ=3, BNE=4, ADDI=5, ANDI=6, ORI=7, XORI=8, LUI=9, SLTI=10, SLTIU=11, J=12) and the 6-bit opcode constants shared with the control decoder.
- Sub-module mips_word_pack: purely combinational class-to-word packer with a legal flag. It is reusable by the testbench reference model.
- This block holds the FSM, address counter, registered write port and error flags.

Test Plan:
1. start, base=0x10. Send ADDI rs=0 rt=8 imm=5, then R rs=8 rt=9 rd=10 shamt=0 funct=0x20 with last -> writes 0x20080005@0x10 and 0x01095020@0x11 on consecutive cycles. done pulses once; word_count=2.
2. LW rs=29 rt=8 imm=4 -> 0x8FA80004. LUI rs=3 rt=1 imm=0x1234 -> 0x3C011234 (rs ignored). J target=0x0000010 -> 0x08000010.
3. in_valid toggled 1,0,1 across back-to-back beats -> imem_we follows the pattern delayed by 1 cycle. Addresses stay contiguous.
4. base=0xFE, three beats without last -> writes at 0xFE and 0xFF. Third beat stalls (in_ready=0), err_full=1, done pulses, word_count=2, no write to 0x00.
5. in_op=14 between two legal beats -> err_op=1. The two legal words land at base and base+1; no gap.
6. rst_n low mid-stream after 3 writes -> all outputs 0 asynchronously. After release, in_valid is ignored until start.
